// File: rtl/pw_ctrl_logic.sv
// Byte-stream command processor: parses 2-byte headers from RX, writes or reads one 512-bit
// password RAM word. Optional write acknowledge byte (0xA5) enabled by CTRL_WRITE_ACK_EN.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// HDR0      | wait for header byte 0 (op, addr high nibble)
// HDR1      | wait for header byte 1 (addr low byte)
// WR_DATA   | assemble payload bytes into dout
// WR_COMMIT | one-cycle RAM write pulse
// RD_REQ    | RAM address/enable presented, wait out read latency
// RD_CAP    | capture RAM read word
// TX        | stream captured word to TX, byte 0 first
// WR_ACK    | send acknowledge byte after a write (optional build)
module pw_ctrl_logic #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 12,
  parameter int WORD_BYTES  = 64,
  parameter int RAM_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    we,
  output logic [ADDR_WIDTH-1:0]   addr,
  input  logic [8*WORD_BYTES-1:0] din,
  output logic [8*WORD_BYTES-1:0] dout,
  output logic                    enb
);

  localparam int CNT_W = $clog2(WORD_BYTES);
  localparam int HI_W  = ADDR_WIDTH - 8;
  localparam int LAT_W = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(WORD_BYTES - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD  = LAT_W'(RAM_LATENCY - 1);

  localparam logic [2:0] HDR0      = 3'd0;
  localparam logic [2:0] HDR1      = 3'd1;
  localparam logic [2:0] WR_DATA   = 3'd2;
  localparam logic [2:0] WR_COMMIT = 3'd3;
  localparam logic [2:0] RD_REQ    = 3'd4;
  localparam logic [2:0] RD_CAP    = 3'd5;
  localparam logic [2:0] TX        = 3'd6;
  localparam logic [2:0] WR_ACK    = 3'd7;

  logic [2:0]             state;
  logic                   op_rd;
  logic [HI_W-1:0]        hdr_hi;
  logic [CNT_W-1:0]       byte_cnt;
  logic [LAT_W-1:0]       lat_cnt;
  logic [8*WORD_BYTES-1:0] word_q;

  logic             rx_fire;
  logic             tx_fire;
  logic             last_byte;
  logic [CNT_W-1:0] byte_nxt;

  assign rx_fire   = rx_valid & rx_ready;
  assign tx_fire   = tx_valid & tx_ready;
  assign last_byte = (byte_cnt == BYTE_LAST);
  assign byte_nxt  = byte_cnt + CNT_W'(1);

  // Outputs are registered and updated on the transition into the state that owns them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= HDR0;
      op_rd    <= 1'b0;
      hdr_hi   <= '0;
      byte_cnt <= '0;
      lat_cnt  <= '0;
      word_q   <= '0;
      rx_ready <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      we       <= 1'b0;
      enb      <= 1'b0;
      addr     <= '0;
      dout     <= '0;
    end else begin
      we <= 1'b0;
      case (state)
        HDR0: begin
          rx_ready <= 1'b1;
          if (rx_fire) begin
            op_rd  <= rx_data[DATA_WIDTH-1];
            hdr_hi <= rx_data[HI_W-1:0];
            state  <= HDR1;
          end
        end
        HDR1: begin
          if (rx_fire) begin
            addr     <= {hdr_hi, rx_data[7:0]};
            byte_cnt <= '0;
            if (op_rd) begin
              rx_ready <= 1'b0;
              enb      <= 1'b1;
              lat_cnt  <= LAT_LOAD;
              state    <= RD_REQ;
            end else begin
              state <= WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (rx_fire) begin
            dout[{byte_cnt, 3'b000} +: 8] <= rx_data;
            byte_cnt <= byte_nxt;
            if (last_byte) begin
              rx_ready <= 1'b0;
              we       <= 1'b1;
              enb      <= 1'b1;
              state    <= WR_COMMIT;
            end
          end
        end
        WR_COMMIT: begin
          enb <= 1'b0;
`ifdef CTRL_WRITE_ACK_EN
          tx_valid <= 1'b1;
          tx_data  <= 8'hA5;
          state    <= WR_ACK;
`else
          rx_ready <= 1'b1;
          state    <= HDR0;
`endif
        end
        RD_REQ: begin
          if (lat_cnt == '0) begin
            state <= RD_CAP;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        RD_CAP: begin
          word_q   <= din;
          enb      <= 1'b0;
          tx_valid <= 1'b1;
          tx_data  <= din[7:0];
          byte_cnt <= '0;
          state    <= TX;
        end
        TX: begin
          if (tx_fire) begin
            if (last_byte) begin
              tx_valid <= 1'b0;
              rx_ready <= 1'b1;
              state    <= HDR0;
            end else begin
              byte_cnt <= byte_nxt;
              tx_data  <= word_q[{byte_nxt, 3'b000} +: 8];
            end
          end
        end
`ifdef CTRL_WRITE_ACK_EN
        WR_ACK: begin
          if (tx_fire) begin
            tx_valid <= 1'b0;
            rx_ready <= 1'b1;
            state    <= HDR0;
          end
        end
`endif
        default: begin
          rx_ready <= 1'b0;
          tx_valid <= 1'b0;
          enb      <= 1'b0;
          state    <= HDR0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pw_ctrl_logic.sv
// Directed bench for pw_ctrl_logic with a behavioural 2-cycle-latency RAM and
// scoreboard queues for expected RAM writes and TX bytes.
module tb_pw_ctrl_logic;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         we;
  logic [11:0]  addr;
  logic [511:0] din;
  logic [511:0] dout;
  logic         enb;

  int vectors = 0;
  int miscompares = 0;

  pw_ctrl_logic dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .we(we), .addr(addr), .din(din), .dout(dout), .enb(enb)
  );

  always #5 clk = ~clk;

  // RAM model: read data appears two edges after addr/enb are sampled.
  logic [511:0] mem [0:4095];
  logic [511:0] rd_pipe;
  always @(posedge clk) begin
    if (enb && we) mem[addr] <= dout;
    if (enb && !we) rd_pipe <= mem[addr];
    din <= rd_pipe;
  end

  logic [7:0]   rx_q[$];
  logic [7:0]   exp_tx[$];
  logic [523:0] exp_wr[$];
  logic [11:0]  exp_rd_addr;
  logic         tx_toggle;
  logic         prev_valid, prev_ready;
  logic [7:0]   prev_data;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int sel, input int k);
    case (sel)
      0: pat = 8'(k);
      1: pat = 8'(k) ^ 8'h5A;
      default: pat = 8'(255 - k);
    endcase
  endfunction

  function automatic logic [511:0] word_of(input int sel);
    logic [511:0] w;
    for (int k = 0; k < 64; k++) w[8*k +: 8] = pat(sel, k);
    return w;
  endfunction

  // One cycle: apply inputs for the coming edge, then check outputs at the negedge.
  task automatic step();
    @(negedge clk);
    if (rx_q.size() > 0) begin
      rx_valid = 1'b1;
      rx_data  = rx_q[0];
    end else begin
      rx_valid = 1'b0;
      rx_data  = 8'h00;
    end
    tx_ready = tx_toggle ? ~tx_ready : 1'b1;
    if (rx_valid && rx_ready) void'(rx_q.pop_front());
    if (prev_valid && !prev_ready)
      chk("tx_stall_hold", {tx_valid, tx_data}, {1'b1, prev_data});
    if (tx_valid) chk("rx_ready_in_tx", rx_ready, 1'b0);
    if (tx_valid && tx_ready) begin
      chk("tx_expected", exp_tx.size() != 0, 1'b1);
      if (exp_tx.size() != 0) chk("tx_byte", tx_data, exp_tx.pop_front());
    end
    if (we) begin
      chk("we_expected", exp_wr.size() != 0, 1'b1);
      if (exp_wr.size() != 0) chk("wr_addr_data", {enb, addr, dout}, {1'b1, exp_wr.pop_front()});
    end
    if (enb && !we) chk("rd_addr", addr, exp_rd_addr);
    prev_valid = tx_valid;
    prev_ready = tx_ready;
    prev_data  = tx_data;
  endtask

  task automatic push_write(input logic [7:0] h0, input logic [7:0] h1,
                            input logic [11:0] a, input int sel, input int first_n);
    rx_q.push_back(h0);
    rx_q.push_back(h1);
    for (int k = 0; k < first_n; k++) rx_q.push_back(pat(sel, k));
    exp_wr.push_back({a, word_of(sel)});
`ifdef CTRL_WRITE_ACK_EN
    exp_tx.push_back(8'hA5);
`endif
  endtask

  task automatic push_read(input logic [7:0] h0, input logic [7:0] h1,
                           input logic [11:0] a, input int sel);
    rx_q.push_back(h0);
    rx_q.push_back(h1);
    exp_rd_addr = a;
    for (int k = 0; k < 64; k++) exp_tx.push_back(pat(sel, k));
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 1000; i++) begin
      if (rx_q.size() == 0 && exp_tx.size() == 0 && exp_wr.size() == 0) break;
      step();
    end
    chk({tag, "_done"}, {rx_q.size() == 0, exp_tx.size() == 0, exp_wr.size() == 0}, 3'b111);
    for (int i = 0; i < 4; i++) step();
    chk({tag, "_hdr0_ready"}, {rx_ready, tx_valid, enb}, 3'b100);
  endtask

  task automatic reset_cycles(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      chk("reset_outputs", {rx_ready, tx_valid, we, enb, addr}, 16'h0);
    end
    rst_n = 1'b1;
    step();
    chk("ready_after_reset", rx_ready, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    tx_toggle = 1'b0;
    exp_rd_addr = 12'h000;
    prev_valid = 1'b0;
    prev_ready = 1'b1;
    prev_data = 8'h00;

    reset_cycles(10);

    push_write(8'h03, 8'h00, 12'h300, 0, 64);
    wait_idle("write_300");

    push_read(8'h83, 8'h00, 12'h300, 0);
    wait_idle("read_300");

    tx_toggle = 1'b1;
    push_read(8'h83, 8'h00, 12'h300, 0);
    wait_idle("read_toggle");
    tx_toggle = 1'b0;

    // payload with a 5-cycle rx_valid gap after byte 20
    push_write(8'h03, 8'h00, 12'h300, 1, 20);
    for (int i = 0; i < 200 && rx_q.size() != 0; i++) step();
    chk("gap_first_part", rx_q.size(), 0);
    for (int i = 0; i < 5; i++) step();
    for (int k = 20; k < 64; k++) rx_q.push_back(pat(1, k));
    wait_idle("write_gap");

    push_read(8'hF3, 8'h00, 12'h300, 1);
    wait_idle("read_reserved");

    push_write(8'h0F, 8'hFF, 12'hFFF, 2, 64);
    wait_idle("write_fff");
    push_read(8'h8F, 8'hFF, 12'hFFF, 2);
    wait_idle("read_fff");

    // abort a write after 30 payload bytes; no write pulse may follow
    rx_q.push_back(8'h05);
    rx_q.push_back(8'h10);
    for (int k = 0; k < 30; k++) rx_q.push_back(8'hEE);
    for (int i = 0; i < 200 && rx_q.size() != 0; i++) step();
    chk("abort_bytes_taken", rx_q.size(), 0);
    reset_cycles(3);
    for (int i = 0; i < 5; i++) step();

    push_read(8'h83, 8'h00, 12'h300, 1);
    wait_idle("read_after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pw_ctrl_logic.md
Name: pw_ctrl_logic

Overview:
- Byte-stream command processor between a UART-style RX/TX FIFO pair and a single-port 512-bit-wide password RAM (4096 words).
- Parses 2-byte command headers from the RX FIFO.
- Write command: assembles 64 payload bytes into one RAM word and writes it.
- Read command: fetches one RAM word and streams its 64 bytes to the TX FIFO.

Parameters:
- DATA_WIDTH, 8, FIFO byte width (only 8 supported).
- ADDR_WIDTH, 12, RAM word address width.
- WORD_BYTES, 64, bytes per RAM word (RAM data width = 8*WORD_BYTES = 512).
- RAM_LATENCY, 2, cycles from address/enable presented to valid RAM read data.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- rx_data  in  8  RX FIFO output byte.
- rx_valid  in  1  RX byte available.
- rx_ready  out  1  block accepts RX byte this cycle.
- tx_data  out  8  byte to TX FIFO.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  TX FIFO can accept.
- we  out  1  RAM write enable (one-cycle pulse).
- addr  out  12  RAM word address.
- din  in  512  RAM read data (RAM douta).
- dout  out  512  RAM write data (RAM dina).
- enb  out  1  RAM access enable.

Behaviour:
- Reset (rst_n=0 at clock edge):
  - Outputs cleared: rx_ready=0, tx_valid=0, tx_data=0, we=0, enb=0, addr=0, dout=0.
  - State returns to HDR0.
  - Reset mid-operation aborts the operation; no write pulse and no further TX bytes.
- Handshakes:
  - RX transfer occurs when rx_valid&rx_ready at a clock edge.
  - TX transfer occurs when tx_valid&tx_ready at a clock edge.
  - tx_data stays stable while tx_valid=1 and tx_ready=0.
- Header byte 0:
  - bit7: 1=read, 0=write.
  - bits[6:4]: reserved, ignored.
  - bits[3:0]: addr[11:8].
- Header byte 1: addr[7:0].
- States:
  - HDR0: rx_ready=1; on accept, latch op and addr[11:8] -> HDR1.
  - HDR1: rx_ready=1; on accept, latch addr[7:0]; write -> WR_DATA, read -> RD_REQ.
  - WR_DATA: rx_ready=1; accepted byte k (k=0..63) goes to dout[8k+7:8k]. After byte 63 -> WR_COMMIT. Gaps in rx_valid are tolerated.
  - WR_COMMIT: we=1 and enb=1 for exactly one cycle with the latched addr -> HDR0.
  - RD_REQ: drive addr, enb=1; count RAM_LATENCY cycles -> RD_CAP.
  - RD_CAP: capture din into the internal word register -> TX.
  - TX: tx_valid=1, tx_data = byte k of the captured word (byte 0 = din[7:0] first). Advance on each TX transfer. After byte 63 transfers, deassert tx_valid -> HDR0.
- rx_ready=0 in RD_REQ, RD_CAP, TX and WR_COMMIT; RX bytes arriving then stay in the FIFO.
- addr holds its last value between commands; addr 0xFFF is legal, with no wrap or auto-increment.
- A read immediately after a write to the same address returns the newly written data (the write completes before HDR0 is re-entered).
- Byte counter is 6 bits; terminal count is 63.

Optional Feature:
- Macro CTRL_WRITE_ACK_EN.
- Defined: after WR_COMMIT, state WR_ACK drives tx_valid=1, tx_data=0xA5 until the TX transfer, then -> HDR0; rx_ready=0 during WR_ACK.
- Undefined: writes produce no TX traffic; WR_COMMIT goes directly to HDR0.

Test Plan:
- Reset held 10 cycles -> rx_ready=0, tx_valid=0, we=0, enb=0, addr=0 during reset; rx_ready=1 the first cycle after release.
- RX 0x03,0x00 then bytes 0x00..0x3F -> single-cycle we=1 with addr=0x300, dout[8k+7:8k]=k for all k; no tx_valid (macro off).
- After that write, RX 0x83,0x00 -> addr=0x300, enb=1; then 64 TX bytes 0x00..0x3F in order; rx_ready=0 until the last byte, then HDR0.
- Read with tx_ready toggling 1/0 every cycle -> tx_data stable while stalled; 64 bytes total, no duplicates or drops.
- Write stream with rx_valid low for 5 cycles mid-payload, then header 0xF3,0x00 read -> reserved bits ignored, read of addr 0x300 returns the written data; header 0x8F,0xFF drives addr=0xFFF.
- Assert rst_n=0 after 30 payload bytes of a write -> no we pulse; next header is parsed fresh from HDR0.
